// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: framing constants, FSM
// state encoding and the frame checksum helper.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;
  localparam logic [7:0] ACK_BYTE    = 8'h06;
  localparam logic [7:0] NAK_BYTE    = 8'h15;
  localparam int         PAYLOAD_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] code, input logic [31:0] data);
    return code ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Signal bundle between the command parser and its RX/TX stages and command sink.
interface uart_cmd_parser_if;

  logic [7:0]  rx_data;
  logic        rx_rec;
  logic        rx_clr;
  logic        tx_idle;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        err_csum;
  logic        err_timeout;

  modport slave (
    input  rx_data, rx_rec, tx_idle,
    output rx_clr, tx_start, tx_data, cmd_code, cmd_data, cmd_valid, err_csum, err_timeout
  );

  modport master (
    output rx_data, rx_rec, tx_idle,
    input  rx_clr, tx_start, tx_data, cmd_code, cmd_data, cmd_valid, err_csum, err_timeout
  );

endinterface

// File: rtl/uart_cmd_parser_gap_timer.sv
// Reusable inter-byte gap timer: reloads on clear, counts down while enabled and
// flags the LOAD-th enabled cycle after the last clear.
module uart_gap_timer #(
  parameter int unsigned LOAD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned      CNT_W = $clog2(LOAD + 1);
  localparam logic [CNT_W-1:0] START = CNT_W'(LOAD - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= START;
    end else if (enable && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign terminal = enable && !clear && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Command-frame parser between the UART RX and TX stages: SOF,CMD,D3..D0,CSUM
// frames with XOR checksum, command strobes and a single ACK/NAK response byte.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned clock_freq    = 100_000_000,
  parameter int unsigned baud_rate     = 115_200,
  parameter int unsigned timeout_chars = 4,
  parameter logic [7:0]  sof_byte      = SOF_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned TMO = clock_freq / baud_rate * 10 * timeout_chars;

  state_t      state, state_nxt;
  logic        accept, clr_block, tmo_hit, timer_clear, timer_en, csum_ok, last_data;
  logic [7:0]  code_q, cmd_code_q, tx_data_q;
  logic [31:0] payload_q, cmd_data_q;
  logic [1:0]  idx_q;
  logic        cmd_valid_q, err_csum_q, err_timeout_q, tx_start_q;

  uart_gap_timer #(.LOAD(TMO)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (tmo_hit)
  );

  assign csum_ok   = (bus.rx_data == frame_csum(code_q, payload_q));
  assign last_data = (idx_q == 2'(PAYLOAD_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // A byte arriving in the terminal-count cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && bus.rx_data == sof_byte) state_nxt = ST_CMD;
      ST_CMD:  if (accept) state_nxt = ST_DATA;
               else if (tmo_hit) state_nxt = ST_IDLE;
      ST_DATA: if (accept) state_nxt = last_data ? ST_CSUM : ST_DATA;
               else if (tmo_hit) state_nxt = ST_IDLE;
      ST_CSUM: if (accept) state_nxt = ST_RESP;
               else if (tmo_hit) state_nxt = ST_IDLE;
      ST_RESP: if (tx_start_q) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RESP leaves rx_rec pending so the next frame's SOF is taken back in IDLE.
  always_comb begin
    accept      = 1'b0;
    timer_en    = 1'b0;
    timer_clear = 1'b1;
    case (state)
      ST_IDLE: accept = bus.rx_rec && !clr_block;
      ST_CMD, ST_DATA, ST_CSUM: begin
        accept      = bus.rx_rec && !clr_block;
        timer_en    = 1'b1;
        timer_clear = accept;
      end
      default: ;
    endcase
  end

  // clr_block resets high so nothing is consumed while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_block     <= 1'b1;
      code_q        <= '0;
      payload_q     <= '0;
      idx_q         <= '0;
      cmd_code_q    <= '0;
      cmd_data_q    <= '0;
      tx_data_q     <= '0;
      cmd_valid_q   <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      tx_start_q    <= 1'b0;
    end else begin
      clr_block     <= accept;
      cmd_valid_q   <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= tmo_hit;
      tx_start_q    <= (state == ST_RESP) && bus.tx_idle && !tx_start_q;
      if (accept) begin
        case (state)
          ST_CMD: begin
            code_q <= bus.rx_data;
            idx_q  <= '0;
          end
          ST_DATA: begin
            payload_q <= {payload_q[23:0], bus.rx_data};
            idx_q     <= idx_q + 2'd1;
          end
          ST_CSUM: begin
            if (csum_ok) begin
              cmd_code_q  <= code_q;
              cmd_data_q  <= payload_q;
              cmd_valid_q <= 1'b1;
              tx_data_q   <= ACK_BYTE;
            end else begin
              err_csum_q <= 1'b1;
              tx_data_q  <= NAK_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_clr      = accept;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.err_csum    = err_csum_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frame table, randomized frames against a
// frame-level model, and hand sequences for timeout, back-to-back and reset.
module tb_uart_cmd_parser;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned TCHARS   = 4;
  localparam int          CHAR_CYC = CLK_FREQ / BAUD * 10;
  localparam int          TMO      = CHAR_CYC * TCHARS;

  logic clk = 1'b0;
  logic rst;

  uart_cmd_parser_if ifc ();

  uart_cmd_parser #(
    .clock_freq    (CLK_FREQ),
    .baud_rate     (BAUD),
    .timeout_chars (TCHARS),
    .sof_byte      (8'hAA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor and TX char-time model
  int cyc = 0;
  int n_clr = 0, n_valid = 0, n_csum = 0, n_tmo = 0, n_tx = 0, n_dbl = 0;
  int last_clr_cyc = 0, valid_cyc = 0, csum_cyc = 0, tx_cyc = 0, busy = 0;
  logic prev_clr = 1'b0;
  logic [7:0] resp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_clr <= ifc.rx_clr;
    if (ifc.rx_clr === 1'b1) begin
      n_clr <= n_clr + 1;
      last_clr_cyc <= cyc;
      if (prev_clr === 1'b1) n_dbl <= n_dbl + 1;
    end
    if (ifc.cmd_valid === 1'b1) begin
      n_valid <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (ifc.err_csum === 1'b1) begin
      n_csum <= n_csum + 1;
      csum_cyc <= cyc;
    end
    if (ifc.err_timeout === 1'b1) n_tmo <= n_tmo + 1;
    if (ifc.tx_start === 1'b1) begin
      n_tx <= n_tx + 1;
      tx_cyc <= cyc;
      resp_q.push_back(ifc.tx_data);
      busy <= CHAR_CYC;
      ifc.tx_idle <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      ifc.tx_idle <= (busy == 1);
    end else begin
      ifc.tx_idle <= 1'b1;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    done = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ifc.rx_data = b;
    ifc.rx_rec  = 1'b1;
    for (int n = 0; n < 2000 && !done; n++) begin
      #1;
      if (ifc.rx_clr === 1'b1) begin
        @(posedge clk);
        #1;
        ifc.rx_rec = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: byte %h got no rx_clr, required one within 2000 cycles", b);
      ifc.rx_rec = 1'b0;
    end
  endtask

  task automatic wait_tx(input int target);
    for (int n = 0; n < 1000 && n_tx < target; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("tx_start_count", n_tx, target);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && ifc.tx_idle !== 1'b1; n++) @(negedge clk);
  endtask

  // Frame-level reference: find the SOF, take the next six bytes as a frame.
  function automatic void model_frame(input logic [7:0] fq[$], output bit good,
                                      output logic [7:0] code, output logic [31:0] data);
    int s;
    logic [7:0] x;
    s = 0;
    while (s < fq.size() && fq[s] != 8'hAA) s++;
    code = fq[s+1];
    data = {fq[s+2], fq[s+3], fq[s+4], fq[s+5]};
    x = 8'h00;
    for (int k = 1; k <= 5; k++) x ^= fq[s+k];
    good = (x == fq[s+6]);
  endfunction

  typedef struct {
    string       name;
    int          nb;
    logic [79:0] bytes;
    int          exp_valid;
    int          exp_csum;
    logic [7:0]  exp_resp;
    logic [7:0]  exp_code;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int b_clr, b_valid, b_csum, b_tmo, b_tx;
    logic [7:0] fq[$];
    logic [7:0] g, code, d, x, e_code, m_code;
    logic [31:0] e_data, m_data;
    bit good;
    int ng;

    // 01^12^34^56^78 = 09; DE AD BE EF with code 05 sums to 27, so 00 is bad
    vecs[0] = '{"good",    7,  80'hAA_01_12_34_56_78_09_000000, 1, 0, 8'h06, 8'h01, 32'h12345678};
    vecs[1] = '{"bad",     7,  80'hAA_05_DE_AD_BE_EF_00_000000, 0, 1, 8'h15, 8'h01, 32'h12345678};
    vecs[2] = '{"garbage", 10, 80'h55_00_FF_AA_7E_00_00_00_01_7F, 1, 0, 8'h06, 8'h7E, 32'h00000001};
    vecs[3] = '{"sof_pay", 7,  80'hAA_10_AA_AA_AA_AA_10_000000, 1, 0, 8'h06, 8'h10, 32'hAAAAAAAA};
    vecs[4] = '{"zeros",   7,  80'hAA_00_00_00_00_00_00_000000, 1, 0, 8'h06, 8'h00, 32'h00000000};
    vecs[5] = '{"ones",    7,  80'hAA_FF_FF_FF_FF_FF_FF_000000, 1, 0, 8'h06, 8'hFF, 32'hFFFFFFFF};

    rst = 1'b0;
    ifc.rx_rec  = 1'b1;
    ifc.rx_data = 8'hAA;
    repeat (4) @(negedge clk);
    check("reset_outputs",
          {ifc.rx_clr, ifc.tx_start, ifc.tx_data, ifc.cmd_code, ifc.cmd_data,
           ifc.cmd_valid, ifc.err_csum, ifc.err_timeout}, 64'h0);
    ifc.rx_rec = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Directed frame table
    for (int i = 0; i < 6; i++) begin
      b_clr = n_clr; b_valid = n_valid; b_csum = n_csum; b_tmo = n_tmo; b_tx = n_tx;
      for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].bytes[79-8*k -: 8], 0);
      wait_tx(b_tx + 1);
      check({vecs[i].name, "_cmd_valid"}, n_valid - b_valid, vecs[i].exp_valid);
      check({vecs[i].name, "_err_csum"}, n_csum - b_csum, vecs[i].exp_csum);
      check({vecs[i].name, "_rx_clr"}, n_clr - b_clr, vecs[i].nb);
      check({vecs[i].name, "_err_timeout"}, n_tmo - b_tmo, 0);
      check({vecs[i].name, "_resp"}, resp_q[$], vecs[i].exp_resp);
      check({vecs[i].name, "_tx_data"}, ifc.tx_data, vecs[i].exp_resp);
      check({vecs[i].name, "_cmd_code"}, ifc.cmd_code, vecs[i].exp_code);
      check({vecs[i].name, "_cmd_data"}, ifc.cmd_data, vecs[i].exp_data);
      if (vecs[i].exp_valid != 0) check({vecs[i].name, "_lat_valid"}, valid_cyc - last_clr_cyc, 1);
      else check({vecs[i].name, "_lat_csum"}, csum_cyc - last_clr_cyc, 1);
      check({vecs[i].name, "_lat_tx_ge2"}, (tx_cyc - last_clr_cyc) >= 2, 1);
      wait_idle();
    end

    // Randomized frames against the frame-level model
    m_code = vecs[5].exp_code;
    m_data = vecs[5].exp_data;
    for (int r = 0; r < 24; r++) begin
      fq.delete();
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom);
        if (g == 8'hAA) g = 8'h55;
        fq.push_back(g);
      end
      fq.push_back(8'hAA);
      code = 8'($urandom);
      fq.push_back(code);
      x = code;
      for (int k = 0; k < 4; k++) begin
        d = ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom);
        fq.push_back(d);
        x ^= d;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      fq.push_back(x);
      model_frame(fq, good, e_code, e_data);
      if (good) begin
        m_code = e_code;
        m_data = e_data;
      end
      b_clr = n_clr; b_valid = n_valid; b_csum = n_csum; b_tx = n_tx;
      foreach (fq[k]) send_byte(fq[k], $urandom_range(0, 4));
      wait_tx(b_tx + 1);
      check("rnd_resp", resp_q[$], good ? 8'h06 : 8'h15);
      check("rnd_cmd_valid", n_valid - b_valid, good ? 1 : 0);
      check("rnd_err_csum", n_csum - b_csum, good ? 0 : 1);
      check("rnd_rx_clr", n_clr - b_clr, fq.size());
      check("rnd_cmd_code", ifc.cmd_code, m_code);
      check("rnd_cmd_data", ifc.cmd_data, m_data);
      wait_idle();
    end

    // Timeout after AA 02 11, then recovery; 02^11^22^33^44 = 46
    b_valid = n_valid; b_tmo = n_tmo; b_tx = n_tx;
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    repeat (TMO - 100) @(negedge clk);
    check("tmo_not_early", n_tmo - b_tmo, 0);
    repeat (200) @(negedge clk);
    check("tmo_err_timeout", n_tmo - b_tmo, 1);
    check("tmo_no_tx_start", n_tx - b_tx, 0);
    check("tmo_no_cmd_valid", n_valid - b_valid, 0);
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'h46, 0);
    wait_tx(b_tx + 1);
    check("tmo_next_valid", n_valid - b_valid, 1);
    check("tmo_next_code", ifc.cmd_code, 8'h02);
    check("tmo_next_data", ifc.cmd_data, 32'h11223344);
    wait_idle();

    // Back-to-back good/bad/good; later SOFs wait out RESP
    b_tx = n_tx; b_valid = n_valid; b_csum = n_csum;
    send_byte(8'hAA, 0); send_byte(8'h21, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h25, 0);
    send_byte(8'hAA, 0); send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'h23, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h22, 0);
    wait_tx(b_tx + 3);
    check("b2b_resp0", resp_q[resp_q.size()-3], 8'h06);
    check("b2b_resp1", resp_q[resp_q.size()-2], 8'h15);
    check("b2b_resp2", resp_q[resp_q.size()-1], 8'h06);
    check("b2b_valid", n_valid - b_valid, 2);
    check("b2b_csum", n_csum - b_csum, 1);
    check("b2b_code", ifc.cmd_code, 8'h23);
    check("b2b_data", ifc.cmd_data, 32'h00000001);
    wait_idle();

    // Reset after D2; trailing D1 D0 CSUM must be dropped in IDLE
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_outputs",
          {ifc.rx_clr, ifc.tx_start, ifc.tx_data, ifc.cmd_code, ifc.cmd_data,
           ifc.cmd_valid, ifc.err_csum, ifc.err_timeout}, 64'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    b_clr = n_clr; b_valid = n_valid; b_csum = n_csum; b_tmo = n_tmo; b_tx = n_tx;
    send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'h47, 0);
    repeat (TMO + 50) @(negedge clk);
    check("rst_tail_rx_clr", n_clr - b_clr, 3);
    check("rst_tail_no_event",
          {n_valid - b_valid, n_csum - b_csum, n_tmo - b_tmo, n_tx - b_tx}, 64'h0);
    check("rst_cmd_code", ifc.cmd_code, 8'h00);
    send_byte(8'hAA, 0); send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    wait_tx(b_tx + 1);
    check("rst_recover_code", ifc.cmd_code, 8'h04);
    check("rst_recover_resp", resp_q[$], 8'h06);

    check("rx_clr_never_double", n_dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
